// File: rtl/sorting_pkg.sv
// Shared types for the sorter/dedup datapath.
package sorting_pkg;
  typedef enum logic [1:0] {DD_IDLE, DD_COLLECT, DD_FLUSH} dedup_state_t;
endpackage

// File: rtl/sorted_dedup_if.sv
// Avalon-ST style streaming bus: master drives data/flags/valid, slave drives ready.
interface sorted_dedup_if #(parameter int DWIDTH = 8);
  logic [DWIDTH-1:0] data;
  logic              startofpacket;
  logic              endofpacket;
  logic              valid;
  logic              ready;

  modport master (output data, startofpacket, endofpacket, valid, input ready);
  modport slave  (input data, startofpacket, endofpacket, valid, output ready);
endinterface

// File: rtl/sorted_dedup.sv
// Drops consecutive equal words of sorted packets; one-word hold lets EOP land on the
// last unique word. Reports duplicate count and ordering violations.
module sorted_dedup
  import sorting_pkg::*;
#(
  parameter int DWIDTH      = 8,
  parameter int MAX_PKT_LEN = 16,
  parameter int CWIDTH      = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic              clk_i,
  input  logic              srst_n_i,
  sorted_dedup_if.slave     snk,
  sorted_dedup_if.master    src,
  output logic [CWIDTH-1:0] dup_cnt_o,
  output logic              order_err_o
);

  dedup_state_t      state_q, state_d;
  logic [DWIDTH-1:0] h_data_q, h_data_d;
  logic              h_first_q, h_first_d;
  logic              h_last_q, h_last_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;
  logic              out_vld_q, out_vld_d;
  logic [CWIDTH-1:0] dup_q, dup_d;
  logic              oerr_q, oerr_d;

  logic out_free, accept;

  assign out_free  = !out_vld_q || src.ready;
  assign snk.ready = (state_q != DD_FLUSH) && out_free;
  assign accept    = snk.valid && snk.ready;

  always_comb begin
    state_d    = state_q;
    h_data_d   = h_data_q;
    h_first_d  = h_first_q;
    h_last_d   = h_last_q;
    out_data_d = out_data_q;
    out_sop_d  = out_sop_q;
    out_eop_d  = out_eop_q;
    out_vld_d  = out_vld_q && !src.ready;
    dup_d      = dup_q;
    oerr_d     = 1'b0;

    case (state_q)
      DD_IDLE: begin
        // words outside a packet are discarded until the next SOP
        if (accept && snk.startofpacket) begin
          h_data_d  = snk.data;
          h_first_d = 1'b1;
          h_last_d  = snk.endofpacket;
          dup_d     = '0;
          state_d   = snk.endofpacket ? DD_FLUSH : DD_COLLECT;
        end
      end
      DD_COLLECT: begin
        if (accept) begin
          if (snk.data == h_data_q) begin
            if (dup_q != CWIDTH'(MAX_PKT_LEN)) dup_d = dup_q + CWIDTH'(1);
          end else begin
            // accept implies the output stage is free this cycle
            out_vld_d  = 1'b1;
            out_data_d = h_data_q;
            out_sop_d  = h_first_q;
            out_eop_d  = 1'b0;
            h_data_d   = snk.data;
            h_first_d  = 1'b0;
            oerr_d     = snk.data < h_data_q;
          end
          if (snk.endofpacket) begin
            h_last_d = 1'b1;
            state_d  = DD_FLUSH;
          end
        end
      end
      DD_FLUSH: begin
        if (out_free) begin
          out_vld_d  = 1'b1;
          out_data_d = h_data_q;
          out_sop_d  = h_first_q;
          out_eop_d  = h_last_q;
          h_first_d  = 1'b0;
          h_last_d   = 1'b0;
          state_d    = DD_IDLE;
        end
      end
      default: state_d = DD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q    <= DD_IDLE;
      h_data_q   <= '0;
      h_first_q  <= 1'b0;
      h_last_q   <= 1'b0;
      out_data_q <= '0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      dup_q      <= '0;
      oerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_data_q   <= h_data_d;
      h_first_q  <= h_first_d;
      h_last_q   <= h_last_d;
      out_data_q <= out_data_d;
      out_sop_q  <= out_sop_d;
      out_eop_q  <= out_eop_d;
      out_vld_q  <= out_vld_d;
      dup_q      <= dup_d;
      oerr_q     <= oerr_d;
    end
  end

  assign src.data          = out_data_q;
  assign src.startofpacket = out_sop_q;
  assign src.endofpacket   = out_eop_q;
  assign src.valid         = out_vld_q;
  assign dup_cnt_o         = dup_q;
  assign order_err_o       = oerr_q;

endmodule

// File: tb/tb_sorted_dedup.sv
// Directed + randomized bench for sorted_dedup against a packet-level reference model.
module tb_sorted_dedup;
  typedef logic [7:0] wq_t[$];
  typedef struct packed {logic [7:0] d; logic s; logic e;} beat_t;

  logic       clk = 0;
  logic       srst_n = 0;
  logic [4:0] dup_cnt;
  logic       order_err;

  sorted_dedup_if #(.DWIDTH(8)) snk_if();
  sorted_dedup_if #(.DWIDTH(8)) src_if();

  sorted_dedup #(.DWIDTH(8), .MAX_PKT_LEN(16)) dut (
    .clk_i(clk), .srst_n_i(srst_n), .snk(snk_if.slave), .src(src_if.master),
    .dup_cnt_o(dup_cnt), .order_err_o(order_err)
  );

  always #5 clk = ~clk;

  int    total = 0, bad = 0;
  int    rmode = 0;
  int    oerr_seen = 0;
  beat_t exp_q[$], got_q[$];
  int    exp_dup, exp_oerr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // src_ready pattern: 0 always, 1 toggle, 2 random, 3 stalled
  always @(negedge clk) begin
    case (rmode)
      0: src_if.ready = 1'b1;
      1: src_if.ready = ~src_if.ready;
      2: src_if.ready = 1'($urandom_range(1));
      default: src_if.ready = 1'b0;
    endcase
  end

  // monitor: samples after the negedge drives settle, i.e. what the next posedge will see
  logic  prev_stall = 0;
  beat_t prev_beat;
  always @(negedge clk) begin
    #2;
    if (srst_n) begin
      if (prev_stall) begin
        chk("stall_valid", 32'(src_if.valid), 32'd1);
        chk("stall_beat", 32'({src_if.data, src_if.startofpacket, src_if.endofpacket}), 32'(prev_beat));
      end
      if (src_if.valid && !src_if.ready) chk("snk_ready_when_full", 32'(snk_if.ready), 32'd0);
      if (src_if.valid && src_if.ready) got_q.push_back({src_if.data, src_if.startofpacket, src_if.endofpacket});
      if (order_err) oerr_seen++;
      prev_stall = src_if.valid && !src_if.ready;
      prev_beat  = {src_if.data, src_if.startofpacket, src_if.endofpacket};
    end else begin
      prev_stall = 0;
    end
  end

  task automatic beat(input logic [7:0] d, input logic s, input logic e);
    int n = 0;
    bit acc = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      snk_if.data = d; snk_if.startofpacket = s; snk_if.endofpacket = e; snk_if.valid = 1'b1;
      #2;
      acc = snk_if.ready;
      n++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 snk_if.valid = 1'b0;
  endtask

  // reference: keep a word unless it equals its predecessor; count drops and descents
  task automatic model(input wq_t w);
    beat_t u[$];
    exp_oerr = 0;
    for (int i = 0; i < w.size(); i++) begin
      if (i == 0 || w[i] != w[i-1]) u.push_back({w[i], 1'b0, 1'b0});
      if (i > 0 && w[i] < w[i-1]) exp_oerr++;
    end
    exp_dup = w.size() - u.size();
    if (exp_dup > 16) exp_dup = 16;
    u[0].s = 1'b1;
    u[u.size()-1].e = 1'b1;
    foreach (u[i]) exp_q.push_back(u[i]);
  endtask

  task automatic drain_check(input string tag);
    int n = 0;
    while (n < 300 && !(got_q.size() >= exp_q.size() && !src_if.valid)) begin
      @(negedge clk); #3; n++;
    end
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_beat"}, 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, "_dup"}, 32'(dup_cnt), 32'(exp_dup));
    chk({tag, "_oerr"}, 32'(oerr_seen), 32'(exp_oerr));
    exp_q.delete(); got_q.delete(); oerr_seen = 0;
  endtask

  task automatic send_pkt(input string tag, input wq_t w);
    model(w);
    foreach (w[i]) beat(w[i], i == 0, i == w.size() - 1);
    drain_check(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk); #3;
    chk({tag, "_valid"}, 32'(src_if.valid), 32'd0);
    chk({tag, "_data"}, 32'({src_if.data, src_if.startofpacket, src_if.endofpacket}), 32'd0);
    chk({tag, "_dup"}, 32'(dup_cnt), 32'd0);
    chk({tag, "_oerr"}, 32'(order_err), 32'd0);
    chk({tag, "_ready"}, 32'(snk_if.ready), 32'd1);
  endtask

  initial begin
    wq_t w;
    snk_if.valid = 0; snk_if.data = 0; snk_if.startofpacket = 0; snk_if.endofpacket = 0;
    src_if.ready = 1;
    repeat (3) @(posedge clk);
    check_reset_vals("reset");
    @(negedge clk) srst_n = 1;

    rmode = 0;
    send_pkt("t1", '{3, 3, 5, 7, 7, 7, 9});
    send_pkt("t2a", '{42});
    send_pkt("t2b", '{6, 6, 6, 6});
    rmode = 1;
    send_pkt("t3", '{1, 2, 3, 4});
    rmode = 0;
    beat(8'hAA, 0, 0);
    beat(8'hBB, 0, 0);
    send_pkt("t4", '{4, 5});
    send_pkt("t5", '{5, 3, 8});

    // reset with one word parked in the stalled output stage
    rmode = 3;
    beat(1, 1, 0);
    beat(2, 0, 0);
    @(negedge clk) srst_n = 0;
    check_reset_vals("t6_reset");
    chk("t6_no_beats", 32'(got_q.size()), 32'd0);
    @(negedge clk) srst_n = 1;
    rmode = 0;
    oerr_seen = 0;
    send_pkt("t6b", '{9, 9});

    rmode = 2;
    for (int p = 0; p < 10; p++) begin
      int len = $urandom_range(16, 1);
      logic [7:0] v = 8'($urandom_range(200));
      w.delete();
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(5))
          0, 1:    v = v;
          2, 3:    v = v + 8'd1;
          4:       v = v + 8'($urandom_range(5));
          default: v = (p % 3 == 0) ? v - 8'($urandom_range(3)) : v;
        endcase
        w.push_back(v);
      end
      send_pkt("rnd", w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
